// File: rtl/tff_counter_controller_pkg.sv
// Shared definitions for the T flip-flop counter controller: the sequencing
// states and the default bank width.
package tff_counter_controller_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        HOLD = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop: toggles on the rising edge whenever t is high,
// synchronously cleared by rst.
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    // Toggle storage with synchronous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/tff_counter_controller.sv
// Sequencer driving a bank of WIDTH T flip-flops as an up/down counter.
// The bank only ever sees per-cell toggle enables; loading the initial
// value and reloading on wrap are both expressed as q XOR target toggles.
module tff_counter_controller
    import tff_counter_controller_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    input  logic             dir,
    input  logic             one_shot,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] t_vec,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic             dir_r;
    logic             one_shot_r;
    logic [WIDTH-1:0] limit_r;
    logic [WIDTH-1:0] init_val;
    logic [WIDTH-1:0] term_val;
    logic             at_term;

    // Toggle pattern for a +1 (down = 0) or -1 (down = 1) step: cell i
    // toggles when every lower cell is 1 (up) or 0 (down).
    function automatic logic [WIDTH-1:0] step_vec(
        input logic [WIDTH-1:0] cur,
        input logic             down
    );
        logic [WIDTH-1:0] v;
        logic             carry;
        carry = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            v[i]  = carry;
            carry = carry & (down ? ~cur[i] : cur[i]);
        end
        return v;
    endfunction

    assign init_val = dir_r ? limit_r : '0;
    assign term_val = dir_r ? '0 : limit_r;
    assign at_term  = (q == term_val);
    assign busy     = (state == LOAD) || (state == RUN) || (state == HOLD);

    // Toggle enables: stop beats hold beats terminal handling beats counting
    always_comb begin
        t_vec = '0;
        case (state)
            LOAD: begin
                if (!stop) begin
                    t_vec = q ^ init_val;
                end
            end
            RUN: begin
                if (stop || hold) begin
                    t_vec = '0;
                end else if (at_term) begin
                    t_vec = one_shot_r ? '0 : (q ^ init_val);
                end else begin
                    t_vec = step_vec(q, dir_r);
                end
            end
            default: t_vec = '0;
        endcase
    end

    // Sequencer state, captured configuration and registered done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dir_r      <= 1'b0;
            one_shot_r <= 1'b0;
            limit_r    <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dir_r      <= dir;
                        one_shot_r <= one_shot;
                        limit_r    <= limit;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    state <= stop ? IDLE : RUN;
                end
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (hold) begin
                        state <= HOLD;
                    end else if (at_term) begin
                        done  <= 1'b1;
                        state <= one_shot_r ? DONE : RUN;
                    end
                end
                HOLD: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (!hold) begin
                        state <= RUN;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The controlled bank of T flip-flops
    for (genvar i = 0; i < WIDTH; i++) begin : g_bank
        tff_cell u_cell (
            .clk (clk),
            .rst (rst),
            .t   (t_vec[i]),
            .q   (q[i])
        );
    end

endmodule
